// File: rtl/posit_encoder.sv
// posit_encoder
//   Packs decoded posit fields (sign, regime value k, 3-bit exponent,
//   mantissa with hidden bit at bit 31, ZERO/NAR flags) into a 32-bit
//   posit word, es = 3. The result is sign-magnitude, i.e. the exact
//   inverse of the posit decoder; no two's complement is applied.
//
//   Build option: define POSIT_ENC_ROUND_EN for round-to-nearest-even
//   with saturation at maxpos; leave it undefined for truncation. Latency
//   is the same in both builds.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      request, sampled only in IDLE
//   received   consumer has taken the result, sampled only in DONE
//   sign       sign bit, copied to posit bit 31
//   k          signed regime value, clamped to [-30, 30]
//   exp_value  exponent field
//   mantissa   {hidden 1, fraction[30:0]}; bit 31 is ignored
//   ZERO       encode zero
//   NAR        encode NaR (wins over ZERO)
//   posit_num  encoded posit, registered
//   done       result valid, held until received
module posit_encoder (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              received,
  input  logic              sign,
  input  logic signed [5:0] k,
  input  logic [2:0]        exp_value,
  input  logic [31:0]       mantissa,
  input  logic              ZERO,
  input  logic              NAR,
  output logic [31:0]       posit_num,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    REGIME = 3'd2,
    TERM   = 3'd3,
    PACK   = 3'd4,
    ROUND  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [63:0] ACC_MSB = 64'h8000_0000_0000_0000;

  state_t             state_r;
  state_t             state_s;
  logic               chk_cyc_r;
  logic               sign_r;
  logic signed [5:0]  k_r;
  logic [2:0]         exp_r;
  logic [30:0]        frac_r;
  logic               zero_r;
  logic               nar_r;
  logic [63:0]        acc_r;
  logic [6:0]         pos_r;
  logic [5:0]         cnt_r;
  logic               rbit_r;
  logic signed [5:0]  k_clamp_s;
  logic [30:0]        body_s;
  logic [30:0]        rounded_s;
`ifdef POSIT_ENC_ROUND_EN
  logic               guard_s;
  logic               sticky_s;
  logic               round_up_s;
`endif

  // Clamp the incoming regime value to the representable range [-30, 30].
  always_comb begin
    k_clamp_s = k;
    if (k < -6'sd30) begin
      k_clamp_s = -6'sd30;
    end else if (k > 6'sd30) begin
      k_clamp_s = 6'sd30;
    end else begin
      k_clamp_s = k;
    end
  end

  // Final body: rounded (nearest-even, saturating at maxpos) or truncated.
  always_comb begin
    body_s = acc_r[63:33];
`ifdef POSIT_ENC_ROUND_EN
    guard_s    = acc_r[32];
    sticky_s   = |acc_r[31:0];
    // An all-ones body is maxpos; rounding it up would wrap, so hold it.
    round_up_s = guard_s & (sticky_s | body_s[0]) & ~(&body_s);
    rounded_s  = body_s + {30'd0, round_up_s};
`else
    rounded_s  = body_s;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CHECK;
        else       state_s = IDLE;
      end
      CHECK: begin
        // First CHECK cycle registers the regime setup; the decision follows.
        if (!chk_cyc_r)           state_s = CHECK;
        else if (nar_r || zero_r) state_s = DONE;
        else                      state_s = REGIME;
      end
      REGIME: begin
        if (cnt_r == 6'd1) state_s = TERM;
        else               state_s = REGIME;
      end
      TERM:    state_s = PACK;
      PACK:    state_s = ROUND;
      ROUND:   state_s = DONE;
      DONE: begin
        if (received) state_s = IDLE;
        else          state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Input latch, regime serialiser, packing and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_cyc_r <= 1'b0;
      sign_r    <= 1'b0;
      k_r       <= 6'sd0;
      exp_r     <= 3'd0;
      frac_r    <= 31'd0;
      zero_r    <= 1'b0;
      nar_r     <= 1'b0;
      acc_r     <= 64'd0;
      pos_r     <= 7'd0;
      cnt_r     <= 6'd0;
      rbit_r    <= 1'b0;
      posit_num <= 32'd0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          chk_cyc_r <= 1'b0;
          if (start) begin
            sign_r <= sign;
            k_r    <= k_clamp_s;
            exp_r  <= exp_value;
            // Bit 31 is the implied hidden one and carries no information.
            frac_r <= mantissa[30:0] | {30'd0, mantissa[31] & 1'b0};
            zero_r <= ZERO;
            nar_r  <= NAR;
          end
        end
        CHECK: begin
          if (!chk_cyc_r) begin
            chk_cyc_r <= 1'b1;
            acc_r     <= 64'd0;
            pos_r     <= 7'd0;
            if (k_r >= 6'sd0) begin
              cnt_r  <= $unsigned(k_r + 6'sd1);
              rbit_r <= 1'b1;
            end else begin
              cnt_r  <= $unsigned(-k_r);
              rbit_r <= 1'b0;
            end
          end else if (nar_r) begin
            posit_num <= 32'h8000_0000;
            done      <= 1'b1;
          end else if (zero_r) begin
            posit_num <= 32'h0000_0000;
            done      <= 1'b1;
          end
        end
        REGIME: begin
          // acc starts cleared, so only 1 bits need writing.
          if (rbit_r) acc_r <= acc_r | (ACC_MSB >> pos_r);
          pos_r <= pos_r + 7'd1;
          cnt_r <= cnt_r - 6'd1;
        end
        TERM: begin
          if (!rbit_r) acc_r <= acc_r | (ACC_MSB >> pos_r);
          pos_r <= pos_r + 7'd1;
        end
        PACK: begin
          acc_r <= acc_r | ({exp_r, frac_r, 30'd0} >> pos_r);
        end
        ROUND: begin
          posit_num <= {sign_r, rounded_s};
          done      <= 1'b1;
        end
        DONE: begin
          if (received) done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/posit_encoder.md
# posit_encoder

Packs decoded posit fields back into a 32-bit posit word (es = 3). It sits directly downstream of the posit decoder and the arithmetic datapath. It consumes the decoder's field format (sign, signed regime value k, 3-bit exponent, mantissa with hidden bit at bit 31, ZERO/NAR flags) and produces a posit word using the same start/done/received handshake.

## Interface
- No parameters; the format is fixed at 32 bits with es = 3.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- received  input  1  consumer has taken the result; sampled only in DONE.
- sign  input  1  sign bit, copied to posit bit 31.
- k  input  6 (signed)  regime value; legal range [-30, 30].
- exp_value  input  3  exponent field.
- mantissa  input  32  {hidden 1, fraction[30:0]}; bit 31 is ignored.
- ZERO  input  1  encode zero.
- NAR  input  1  encode NaR; has priority over ZERO.
- posit_num  output  32  encoded posit, registered.
- done  output  1  result valid; held until received.

## Operation
- Output format is sign-magnitude, the exact inverse of the decoder: {sign, regime, exp, fraction}. No two's complement is applied.
- **Input latch:** all inputs are latched on the edge where start is sampled in IDLE. Inputs are don't-care afterwards.
- **k clamping:** k < -30 is treated as -30; k > 30 is treated as 30.
- **State machine:** IDLE → CHECK → REGIME → TERM → PACK → ROUND → DONE → IDLE.
- **IDLE:** done = 0. On start, latch the inputs and go to CHECK.
- **CHECK:**
  - If NAR: posit_num = 0x80000000, done = 1, go to DONE.
  - Else if ZERO: posit_num = 0x00000000, done = 1, go to DONE.
  - Else: clear the 64-bit accumulator acc and the 7-bit bit pointer pos. Set cnt = k+1 and rbit = 1 when k ≥ 0; otherwise cnt = -k and rbit = 0. Go to REGIME.
- **REGIME:** each cycle, write rbit at acc[63-pos], pos += 1, cnt -= 1. When cnt reaches 0, go to TERM.
- **TERM:** write ~rbit at acc[63-pos], pos += 1, go to PACK. TERM runs even when k = 30; that terminator lands in the guard position.
- **PACK:** acc |= {exp_value, mantissa[30:0], 30'b0} >> pos. Go to ROUND.
- **ROUND:**
  - Fields: body = acc[63:33], guard = acc[32], sticky = |acc[31:0].
  - Round-up condition (round-to-nearest-even): guard & (sticky | body[0]).
  - Round-up is suppressed when body = all ones, so the result saturates at maxpos.
  - A body of 0 cannot occur.
  - Register posit_num = {sign, rounded body}, done = 1, go to DONE.
- **DONE:** posit_num and done are held. When received = 1, the next edge goes to IDLE with done = 0; posit_num keeps its value.
- start outside IDLE is ignored.

## Timing
- Reset values: posit_num = 0, done = 0, state = IDLE, acc = 0, pos = 0, cnt = 0.
- Reset mid-operation aborts immediately with no output.
- Let E0 be the edge where start is sampled. done rises at:
  - NAR/ZERO: E0+2.
  - Normal: E0+cnt+5, where cnt = k+1 for k ≥ 0 and -k for k < 0.
  - Examples: k=0 → E0+6; k=-1 → E0+6; k=-30 → E0+35; k=30 → E0+36.
- received asserted in the first DONE cycle is honoured, giving a one-cycle done pulse.
- Back-to-back operation: start can be sampled at the earliest one cycle after done falls.

## Configuration
- **POSIT_ENC_ROUND_EN defined:** round-to-nearest-even with maxpos saturation, as above.
- **POSIT_ENC_ROUND_EN undefined:** truncation, posit body = acc[63:33]. guard and sticky are unused. The ROUND state remains, so latency is identical.

## Test plan
- NAR=1, ZERO=1 → posit_num 0x80000000, done at E0+2. Then NAR=0, ZERO=1 → 0x00000000.
- k=0, exp=0, mantissa=0x80000000, sign=0 → 0x40000000, done at E0+6. Same with sign=1, k=-1, exp=5 → 0xB4000000.
- k=0, exp=0, mantissa=0x80000010 (tie, even LSB) → 0x40000000. mantissa=0x80000030 → 0x40000002 with the macro, 0x40000001 without.
- k=29, exp=7, mantissa=0xFFFFFFFF → 0x7FFFFFFF with the macro (rounds to maxpos), 0x7FFFFFFE without. k=30 → 0x7FFFFFFF, done at E0+36. k=31 → clamped, same result as k=30.
- k=-30 → 0x00000001, done at E0+35. k=-32 → clamped, same result.
- Handshake and reset:
  - received held low → done and posit_num stable for 20 cycles.
  - start pulses during processing → ignored.
  - rst low mid-REGIME → done = 0, posit_num = 0, state IDLE; a new request then completes correctly.
